// File: rtl/rotate_left_8_pipe.sv
// rotate_left_8_pipe: pipelined rotate-left unit with valid/ready handshakes on both sides.
//
// Operand a is rotated left by b[AMT_W-1:0]. There is one log-shifter level per stage:
// stage 0 rotates by 1, stage 1 by 2, stage 2 by 4, and so on. Latency is AMT_W cycles and
// throughput is one result per cycle. A combinational ready chain provides full backpressure
// without bubbles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   block accepts the operand pair this cycle
//   a          operand to rotate (WIDTH bits)
//   b          rotate amount (WIDTH bits, only b[AMT_W-1:0] used)
//   out_valid  result s is valid
//   out_ready  downstream accepts s this cycle
//   s          rotated result, driven from the last stage register

module rotate_left_8_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s
);

    // Per-stage state: valid bit, data so far and the full amount (later stages read higher bits).
    logic [AMT_W-1:0]                  v_q;
    logic [AMT_W-1:0][WIDTH-1:0]       data_q;
    logic [AMT_W-1:0][AMT_W-1:0]       amt_q;

    // What each stage would load this cycle.
    logic [AMT_W-1:0]                  rdy;
    logic [AMT_W-1:0]                  up_v;
    logic [AMT_W-1:0][WIDTH-1:0]       up_d;
    logic [AMT_W-1:0][AMT_W-1:0]       up_a;
    logic [AMT_W-1:0][WIDTH-1:0]       rot_d;

    // Rotate x left by n (n < WIDTH). The upper half of {x, x} << n is the rotated word.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int unsigned n);
        logic [2*WIDTH-1:0] t;
        t = {x, x} << n;
        return t[2*WIDTH-1 -: WIDTH];
    endfunction

    // A stage can load when it is empty or its contents move on this cycle.
    always_comb begin
        rdy = '0;
        rdy[AMT_W-1] = out_ready | ~v_q[AMT_W-1];
        for (int k = int'(AMT_W) - 2; k >= 0; k--) begin
            rdy[k] = ~v_q[k] | rdy[k+1];
        end
    end

    always_comb begin
        up_v  = '0;
        up_d  = '0;
        up_a  = '0;
        rot_d = '0;
        up_v[0] = in_valid;
        up_d[0] = a;
        up_a[0] = b[AMT_W-1:0];
        for (int unsigned k = 1; k < AMT_W; k++) begin
            up_v[k] = v_q[k-1];
            up_d[k] = data_q[k-1];
            up_a[k] = amt_q[k-1];
        end
        for (int unsigned k = 0; k < AMT_W; k++) begin
            rot_d[k] = up_a[k][k] ? rotl(up_d[k], 1 << k) : up_d[k];
        end
    end

    // Data only loads with a valid item, so s keeps the last result while the pipe drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            data_q <= '0;
            amt_q  <= '0;
        end else begin
            for (int unsigned k = 0; k < AMT_W; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= up_v[k];
                    if (up_v[k]) begin
                        data_q[k] <= rot_d[k];
                        amt_q[k]  <= up_a[k];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[AMT_W-1];
    assign s         = data_q[AMT_W-1];

    // Upper amount bits are ignored; low amount bits are dead once their stage has passed.
    logic unused_bits;
    assign unused_bits = ^{b[WIDTH-1:AMT_W], amt_q};

endmodule

// File: tb/tb_rotate_left_8_pipe.sv
module tb_rotate_left_8_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] s;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    rotate_left_8_pipe #(
        .WIDTH(8),
        .AMT_W(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_rotl(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    function automatic logic [7:0] ref_rotr(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[0], y[7:1]};
        return y;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation with out_ready high; result expected after the 3rd edge.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_amt,
                          input logic [7:0] exp);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_amt;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        tick();
        check({tag, "_early"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_s"}, s, exp);
        tick();
        check({tag, "_drop"}, out_valid, 0);
    endtask

    initial begin
        logic [7:0] exp_tbl[7];
        logic [7:0] ta;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       seen;
        int         acc;
        int         got;

        exp_tbl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        out_ready = 1'b1;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_s", s, 8'h00);
        #10 rst_n = 1'b1;
        tick();

        // Single op and amount corners
        run_op("single_b3", 8'hB1, 8'h03, 8'h8D);
        run_op("b0", 8'hB1, 8'h00, 8'hB1);
        run_op("b7", 8'hB1, 8'h07, 8'hD8);
        run_op("bFB", 8'hB1, 8'hFB, 8'h8D);
        for (int i = 1; i <= 7; i++) begin
            run_op($sformatf("one_b%0d", i), 8'h01, 8'(i), exp_tbl[i-1]);
        end

        // Throughput: 16 back-to-back items, item j visible at sample point j+3
        for (int n = 0; n < 20; n++) begin
            if (n >= 3 && n <= 18) begin
                check($sformatf("thru_valid_%0d", n), out_valid, 1);
                ta = 8'((n - 3) * 17);
                check($sformatf("thru_s_%0d", n), s, ref_rotl(ta, (n - 3) % 8));
            end else begin
                check($sformatf("thru_idle_%0d", n), out_valid, 0);
            end
            if (n < 16) begin
                in_valid = 1'b1;
                a        = 8'(n * 17);
                b        = 8'(n);
                #1;
                check($sformatf("thru_in_ready_%0d", n), in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end

        // Backpressure: fill with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'hC3; b = 8'h01; #1; check("bp_rdy0", in_ready, 1); tick();
        a = 8'h5A; b = 8'h02; #1; check("bp_rdy1", in_ready, 1); tick();
        a = 8'hE7; b = 8'h03; #1; check("bp_rdy2", in_ready, 1); tick();
        a = 8'hFF; b = 8'h01; #1;
        check("bp_full", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
            check($sformatf("bp_hold_s_%0d", i), s, 8'h87);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_d0_valid", out_valid, 1);
        check("bp_d0_s", s, 8'h87);
        tick();
        check("bp_d1_valid", out_valid, 1);
        check("bp_d1_s", s, 8'h69);
        tick();
        check("bp_d2_valid", out_valid, 1);
        check("bp_d2_s", s, 8'h3F);
        tick();
        check("bp_empty", out_valid, 0);

        // Reset with two items in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'h12; b = 8'h01; tick();
        a = 8'h34; b = 8'h02; tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_s", s, 8'h00);
        check("mid_rst_in_ready", in_ready, 1);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("post_rst_quiet", seen, 0);

        // Random traffic against a scoreboard
        acc = 0;
        got = 0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            in_valid  = (acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            a         = 8'($urandom);
            b         = 8'($urandom);
            out_ready = 1'($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q_a.size() == 0) begin
                    check("rnd_extra", 1, 0);
                end else begin
                    ea = q_a.pop_front();
                    eb = q_b.pop_front();
                    check("rnd_s", s, ref_rotl(ea, int'(eb[2:0])));
                    check("rnd_inverse", ref_rotr(s, int'(eb[2:0])), ea);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q_a.push_back(a);
                q_b.push_back(b);
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("rnd_count", got, 1000);
        check("rnd_leftover", q_a.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
